// File: rtl/wash_scheduler.sv
// Round-robin sharing of one washer between coin-operated kiosks.
// Define WASH_SCHED_REFUND_EN to return credits on an abort from LOAD.
module wash_scheduler #(
    parameter int N_REQ        = 4,
    parameter int PRICE        = 3,
    parameter int CW           = 3,
    parameter int LOAD_TIMEOUT = 2500
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_coin,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [2*N_REQ-1:0] i_mode_sel,
    input  logic [N_REQ-1:0]   i_cancel,
    input  logic               i_wash_idle,
    input  logic               i_wash_busy,
    input  logic               i_wash_done,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_wash_coin,
    output logic [3:0]         o_wash_mode,
    output logic               o_wash_cancel,
    output logic [N_REQ-1:0]   o_job_done,
    output logic [N_REQ-1:0]   o_credit_ok
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
    localparam logic [CW+1:0] PRICE_W  = (CW+2)'(PRICE);
    localparam logic [CW+1:0] MAX_W    = (CW+2)'((1 << CW) - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOAD_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
`ifdef WASH_SCHED_REFUND_EN
    localparam bit REFUND_EN = 1'b1;
`else
    localparam bit REFUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_LOAD, S_RUN, S_ABORT, S_DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    last;
    logic [TW-1:0]    tmo;
    logic             from_load;
    logic [CW-1:0]    credit     [N_REQ];
    logic [CW-1:0]    credit_nxt [N_REQ];
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] deduct;
    logic [N_REQ-1:0] refund;
    logic             any_elig;
    logic [IW-1:0]    win;
    logic             start;

    function automatic logic [3:0] mode_onehot(input logic [1:0] m);
        logic [3:0] r;
        unique case (m)
            2'b00:   r = 4'b0001;
            2'b01:   r = 4'b0010;
            2'b10:   r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            o_credit_ok[k] = credit[k] >= PRICE_C;
            elig[k] = i_req[k] && (credit[k] >= PRICE_C) && !i_cancel[k];
        end
    end

    // First eligible kiosk scanning upward from the one after the last winner
    always_comb begin
        int j;
        logic [IW-1:0] idx;
        j = 0;
        idx = '0;
        win = '0;
        any_elig = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(last) + 1 + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (j >= N_REQ) j = j - N_REQ;
            idx = IW'(j);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                win = idx;
            end
        end
    end

    assign start  = (state == S_IDLE) && i_wash_idle && any_elig;
    assign deduct = start ? (N_REQ'(1) << win) : '0;
    assign refund = (REFUND_EN && state == S_ABORT && from_load)
                  ? (N_REQ'(1) << owner) : '0;

    always_comb begin
        logic [CW+1:0] sum;
        sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {2'b00, credit[k]} + (CW+2)'(i_coin[k]);
            if (deduct[k]) sum = sum - PRICE_W;
            if (refund[k]) sum = sum + PRICE_W;
            credit_nxt[k] = (sum > MAX_W) ? MAX_W[CW-1:0] : sum[CW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_REQ; k++) credit[k] <= '0;
        end else begin
            credit <= credit_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            owner         <= '0;
            last          <= LAST_RST;
            tmo           <= '0;
            from_load     <= 1'b0;
            o_grant       <= '0;
            o_wash_coin   <= 1'b0;
            o_wash_mode   <= '0;
            o_wash_cancel <= 1'b0;
            o_job_done    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_GRANT;
                        owner       <= win;
                        last        <= win;
                        o_grant     <= N_REQ'(1) << win;
                        o_wash_coin <= 1'b1;
                        o_wash_mode <= mode_onehot(i_mode_sel[{win, 1'b0} +: 2]);
                    end
                end
                S_GRANT: begin
                    o_wash_coin <= 1'b0;
                    tmo         <= '0;
                    state       <= S_LOAD;
                end
                S_LOAD: begin
                    if (i_cancel[owner]) begin
                        state         <= S_ABORT;
                        o_wash_cancel <= 1'b1;
                        from_load     <= 1'b1;
                    end else if (i_wash_busy) begin
                        state <= S_RUN;
                    end else if (tmo == TO_LAST) begin
                        state         <= S_ABORT;
                        o_wash_cancel <= 1'b1;
                        from_load     <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_wash_done) begin
                        state      <= S_DONE;
                        o_job_done <= o_grant;
                    end else if (i_cancel[owner]) begin
                        state         <= S_ABORT;
                        o_wash_cancel <= 1'b1;
                        from_load     <= 1'b0;
                    end
                end
                S_ABORT: begin
                    o_wash_cancel <= 1'b0;
                    from_load     <= 1'b0;
                    o_grant       <= '0;
                    o_wash_mode   <= '0;
                    state         <= S_IDLE;
                end
                S_DONE: begin
                    o_job_done  <= '0;
                    o_grant     <= '0;
                    o_wash_mode <= '0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wash_scheduler.sv
// Directed bench for wash_scheduler: vector table plus multi-cycle sequences.
module tb_wash_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] coin, req, cancel;
    logic [7:0] msel;
    logic       widle, wbusy, wdone;
    logic [3:0] grant, wmode, jdone, cok;
    logic       wcoin, wcancel;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef WASH_SCHED_REFUND_EN
    localparam int REF = 3;
`else
    localparam int REF = 0;
`endif

    always #5 clk = ~clk;

    wash_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_coin        (coin),
        .i_req         (req),
        .i_mode_sel    (msel),
        .i_cancel      (cancel),
        .i_wash_idle   (widle),
        .i_wash_busy   (wbusy),
        .i_wash_done   (wdone),
        .o_grant       (grant),
        .o_wash_coin   (wcoin),
        .o_wash_mode   (wmode),
        .o_wash_cancel (wcancel),
        .o_job_done    (jdone),
        .o_credit_ok   (cok)
    );

    typedef struct packed {
        logic [3:0] coin;
        logic [3:0] req;
        logic [7:0] msel;
        logic [3:0] cancel;
        logic       idle;
        logic       busy;
        logic       done;
        logic [3:0] e_grant;
        logic       e_coin;
        logic [3:0] e_mode;
        logic       e_cancel;
        logic [3:0] e_jd;
        logic [3:0] e_ok;
    } vec_t;

    vec_t tv [8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        coin = '0; req = '0; cancel = '0; msel = '0;
        widle = 1'b1; wbusy = 1'b0; wdone = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string nm);
        int n;
        n = 0;
        while (grant == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " grant seen"}, 32'(grant != 4'b0), 1);
    endtask

    task automatic run_job(input logic [3:0] exp, input string nm);
        wait_grant(nm);
        check({nm, " owner"}, grant, exp);
        check({nm, " coin"}, wcoin, 1);
        widle = 1'b0;
        @(negedge clk);
        wbusy = 1'b1;
        @(negedge clk);
        wdone = 1'b1;
        @(negedge clk);
        check({nm, " job_done"}, jdone, exp);
        wdone = 1'b0; wbusy = 1'b0; widle = 1'b1;
        @(negedge clk);
        check({nm, " grant cleared"}, grant, 0);
    endtask

    initial begin
        // coin,req,msel,cancel,idle,busy,done | grant,coin,mode,cancel,jd,ok
        tv[0] = '{4'b0100, 4'b0000, 8'h00, 4'b0000, 1, 0, 0,
                  4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000};
        tv[1] = '{4'b0100, 4'b0000, 8'h00, 4'b0000, 1, 0, 0,
                  4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000};
        tv[2] = '{4'b0100, 4'b0000, 8'h00, 4'b0000, 1, 0, 0,
                  4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0100};
        tv[3] = '{4'b0000, 4'b0100, 8'h10, 4'b0000, 1, 0, 0,
                  4'b0100, 1, 4'b0010, 0, 4'b0000, 4'b0000};
        tv[4] = '{4'b0000, 4'b0000, 8'hff, 4'b0010, 0, 0, 1,
                  4'b0100, 0, 4'b0010, 0, 4'b0000, 4'b0000};
        tv[5] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 1, 0,
                  4'b0100, 0, 4'b0010, 0, 4'b0000, 4'b0000};
        tv[6] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 1, 1,
                  4'b0100, 0, 4'b0010, 0, 4'b0100, 4'b0000};
        tv[7] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1, 0, 0,
                  4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000};

        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset grant", grant, 0);
        check("reset coin", wcoin, 0);
        check("reset mode", wmode, 0);
        check("reset cancel", wcancel, 0);
        check("reset job_done", jdone, 0);
        check("reset credit_ok", cok, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            coin = tv[i].coin; req = tv[i].req; msel = tv[i].msel;
            cancel = tv[i].cancel; widle = tv[i].idle;
            wbusy = tv[i].busy; wdone = tv[i].done;
            @(negedge clk);
            check($sformatf("vec%0d grant", i), grant, tv[i].e_grant);
            check($sformatf("vec%0d coin", i), wcoin, tv[i].e_coin);
            check($sformatf("vec%0d mode", i), wmode, tv[i].e_mode);
            check($sformatf("vec%0d cancel", i), wcancel, tv[i].e_cancel);
            check($sformatf("vec%0d job_done", i), jdone, tv[i].e_jd);
            check($sformatf("vec%0d credit_ok", i), cok, tv[i].e_ok);
        end
        check("k2 credit after job", dut.credit[2], 0);

        // round robin over kiosks 0, 1, 3
        do_reset();
        coin = 4'b1011;
        repeat (6) @(negedge clk);
        coin = '0;
        req = 4'b1011;
        run_job(4'b0001, "rr1");
        run_job(4'b0010, "rr2");
        run_job(4'b1000, "rr3");
        run_job(4'b0001, "rr4");

        // LOAD timeout
        do_reset();
        coin = 4'b0001;
        repeat (3) @(negedge clk);
        coin = '0;
        req = 4'b0001;
        wait_grant("tmo");
        req = '0; widle = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wcancel && n < 3000);
            check("timeout cycles", n, 2501);
        end
        @(negedge clk);
        check("timeout cancel one cycle", wcancel, 0);
        check("timeout grant cleared", grant, 0);
        check("timeout credit", dut.credit[0], REF);

        // owner cancel in RUN: no refund
        do_reset();
        coin = 4'b0001;
        repeat (6) @(negedge clk);
        coin = '0;
        req = 4'b0001;
        wait_grant("runcan");
        req = '0; widle = 1'b0;
        @(negedge clk);
        wbusy = 1'b1;
        @(negedge clk);
        cancel = 4'b0001;
        @(negedge clk);
        check("runcan cancel pulse", wcancel, 1);
        check("runcan no job_done", jdone, 0);
        cancel = '0; wbusy = 1'b0; widle = 1'b1;
        @(negedge clk);
        check("runcan cancel end", wcancel, 0);
        check("runcan grant cleared", grant, 0);
        check("runcan credit", dut.credit[0], 3);

        // cancel and busy together in LOAD: cancel wins
        req = 4'b0001;
        wait_grant("ldcan");
        req = '0; widle = 1'b0; wbusy = 1'b1; cancel = 4'b0001;
        @(negedge clk);
        check("ldcan load no cancel", wcancel, 0);
        @(negedge clk);
        check("ldcan cancel pulse", wcancel, 1);
        cancel = '0; wbusy = 1'b0; widle = 1'b1;
        @(negedge clk);
        check("ldcan credit", dut.credit[0], REF);

        // saturation and coin during the deduct cycle
        do_reset();
        coin = 4'b0010;
        repeat (9) @(negedge clk);
        coin = '0;
        check("sat credit", dut.credit[1], 7);
        check("sat credit_ok", cok, 4'b0010);
        coin = 4'b0010; req = 4'b0010;
        @(negedge clk);
        coin = '0; req = '0;
        check("sat grant", grant, 4'b0010);
        check("sat credit after grant", dut.credit[1], 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_scheduler.md
# wash_scheduler

Shares one `wash_design` washer between `N_REQ` coin-operated customer kiosks. Each kiosk has its own coin credit counter. A round-robin arbiter grants the washer to one eligible kiosk and forwards a coin pulse and the latched mode to the washer. It then supervises the job until it completes, is cancelled or times out. The block sits between the kiosk front panels and the washer's `i_coin`/`i_mode_*`/`i_cancel` inputs.

## Interface
- `N_REQ`, 4: number of kiosks.
- `PRICE`, 3: credits consumed per job (1..`2**CW-1`).
- `CW`, 3: credit counter width; saturates at `2**CW-1`.
- `LOAD_TIMEOUT`, 2500: max cycles in LOAD before abort (10 s at 250 Hz).
- `i_clk`, in, 1: clock, 250 Hz.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_coin`, in, `N_REQ`: per-kiosk coin pulse; one credit per high cycle.
- `i_req`, in, `N_REQ`: per-kiosk level request to run a job.
- `i_mode_sel`, in, `2*N_REQ`: kiosk k mode is bits [2k+1:2k]. 00 maps to mode_1, 01 to mode_2, 10 to mode_3, 11 to mode_4.
- `i_cancel`, in, `N_REQ`: per-kiosk cancel level.
- `i_wash_idle`, in, 1: washer `o_idle`.
- `i_wash_busy`, in, 1: OR of washer `o_soak`, `o_wash`, `o_rinse` and `o_spin`.
- `i_wash_done`, in, 1: washer `o_done`.
- `o_grant`, out, `N_REQ`: one-hot owner of the washer; all-zero when none.
- `o_wash_coin`, out, 1: one-cycle coin pulse to the washer.
- `o_wash_mode`, out, 4: one-hot to washer `i_mode_1..4`; held from grant until the job ends.
- `o_wash_cancel`, out, 1: one-cycle pulse to washer `i_cancel`.
- `o_job_done`, out, `N_REQ`: one-cycle pulse on the owner's bit when the job completes.
- `o_credit_ok`, out, `N_REQ`: kiosk credit is at least `PRICE`.

## Operation
- Credits: `credit[k]` increments on `i_coin[k]` and saturates. A grant deducts `PRICE`. A coin arriving in the same cycle as the deduct gives `credit - PRICE + 1`. A refund adds `PRICE`, saturating.
- Eligibility: kiosk k is eligible when `i_req[k]`, `credit[k] >= PRICE` and `!i_cancel[k]`. The check uses registered credit and ignores the current cycle's coin.
- Arbitration: round-robin. The search starts at `last+1` modulo `N_REQ`. `last` updates on every grant.
- States:
  - IDLE: when `i_wash_idle` is high and any kiosk is eligible, go to GRANT. Latch the winner and its mode, and deduct credit.
  - GRANT (1 cycle): `o_wash_coin` is 1. Go to LOAD.
  - LOAD: wait for `i_wash_busy`, then go to RUN. If the timeout counter reaches `LOAD_TIMEOUT`, or `i_cancel[owner]` is seen, go to ABORT.
  - RUN: `i_wash_done` leads to DONE. `i_cancel[owner]` leads to ABORT (no refund).
  - ABORT (1 cycle): `o_wash_cancel` is 1. Apply the refund if it is enabled and the abort came from LOAD. Go to IDLE.
  - DONE (1 cycle): `o_job_done[owner]` is 1. Go to IDLE.
- `o_grant` and `o_wash_mode` are valid from GRANT through the last cycle of ABORT or DONE. Both are zero in IDLE.
- Cancel from a non-owner kiosk is ignored and its credit is kept. A later change to `i_mode_sel` does not alter the latched mode.
- `i_wash_done` outside RUN is ignored. If `i_wash_busy` and `i_cancel[owner]` are both high in LOAD, cancel wins and the block goes to ABORT.

## Timing
- Reset values:
  - all outputs 0;
  - credits 0;
  - `last` = `N_REQ-1`, so kiosk 0 wins first;
  - state IDLE;
  - timeout counter 0.
- Reset mid-job clears everything. No cancel pulse is issued; the washer is expected to share reset or be returned to idle by its own start.
- Latency:
  - eligible and washer idle at cycle t gives `o_grant`, `o_wash_coin` and `o_wash_mode` at t+1;
  - state is LOAD from t+2.
- `o_job_done` is asserted the cycle after `i_wash_done`.
- The LOAD timeout counter clears on entry to LOAD and is compared at `LOAD_TIMEOUT` cycles.
- Minimum gap between jobs: one IDLE cycle after DONE or ABORT.

## Configuration
- `WASH_SCHED_REFUND_EN`:
  - Defined: an abort from LOAD (timeout or owner cancel) returns `PRICE` credits to the owner.
  - Undefined: credits are forfeited. Abort from RUN never refunds in either build.

## Test plan
- Kiosk 2 gets 3 coins, sets `i_req[2]` with mode 01 while the washer is idle. Expect `o_grant`=0100, one `o_wash_coin` pulse and `o_wash_mode`=0010 one cycle later, and credit[2]=0.
- Kiosks 0, 1 and 3 all eligible over three back-to-back jobs. Expect grants in order 0, 1, 3; kiosk 0 is granted again only after 3.
- After grant, hold `i_wash_busy`=0. Expect ABORT with `o_wash_cancel` pulsed at exactly 2500 LOAD cycles. Credit is restored to 3 with REFUND_EN and stays 0 without it.
- Owner cancels in RUN. Expect an `o_wash_cancel` pulse, no refund, no `o_job_done`, then IDLE.
- 9 coins on kiosk 1 saturate credit at 7. A coin in the grant cycle leaves credit 5 (7-3+1).
- Pulse `i_wash_done` in RUN. Expect `o_job_done[owner]` for one cycle, then `o_grant`=0.
